// File: rtl/xray_pixel_stream_engine.sv
// Point-operation engine for raster X-ray frames: a valid/ready stream of LANES
// pixels per beat, one saturating operation per frame, frame-position flags on
// each output beat and a per-frame count of hot (>= threshold) pixels.
module xray_pixel_stream_engine #(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned LANES = 1,
  parameter int unsigned IMG_W = 382,
  parameter int unsigned IMG_H = 256
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [2:0]                           mode,
  input  logic [PIX_W-1:0]                     value,
  input  logic [PIX_W-1:0]                     threshold,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  input  logic [PIX_W*LANES-1:0]               s_data,
  output logic                                 m_valid,
  input  logic                                 m_ready,
  output logic [PIX_W*LANES-1:0]               m_data,
  output logic                                 m_sof,
  output logic                                 m_eol,
  output logic                                 m_eof,
  output logic [$clog2(IMG_W*IMG_H+1)-1:0]     hot_count,
  output logic                                 hot_valid
);

  localparam int unsigned BEATS = IMG_W / LANES;
  localparam int unsigned DW    = PIX_W * LANES;
  localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned HCW   = $clog2(IMG_W * IMG_H + 1);
  localparam int unsigned LCW   = $clog2(LANES + 1);
  localparam logic [PIX_W-1:0] MAX = {PIX_W{1'b1}};

  logic [CW-1:0]    r_col;
  logic [RW-1:0]    r_row;
  logic [2:0]       r_mode;
  logic [PIX_W-1:0] r_val;
  logic [PIX_W-1:0] r_thr;
  logic             r_s1_valid;
  logic [DW-1:0]    r_s1_data;
  logic             r_s1_sof;
  logic             r_s1_eol;
  logic             r_s1_eof;
  logic [HCW-1:0]   r_acc;

  logic             w_en;
  logic             w_acc;
  logic             w_sof;
  logic             w_eol;
  logic             w_eof;
  logic [2:0]       w_mode;
  logic [PIX_W-1:0] w_val;
  logic [PIX_W-1:0] w_thr;
  logic [DW-1:0]    w_res;
  logic [LCW-1:0]   w_hot;

  // One pixel through the selected saturating point operation.
  function automatic logic [PIX_W-1:0] f_op(input logic [2:0] m, input logic [PIX_W-1:0] p,
                                            input logic [PIX_W-1:0] v, input logic [PIX_W-1:0] t);
    logic [PIX_W:0]   w_sum;
    logic [PIX_W-1:0] w_dif;
    logic [PIX_W:0]   w_str;
    w_sum = {1'b0, p} + {1'b0, v};
    w_dif = p - v;
    w_str = {1'b0, w_dif} << 1;
    f_op  = p;
    case (m)
      3'd1: f_op = w_sum[PIX_W] ? MAX : w_sum[PIX_W-1:0];
      3'd2: f_op = (p >= v) ? w_dif : '0;
      3'd3: f_op = (p >= t) ? MAX : '0;
      3'd4: f_op = MAX - p;
      3'd5: begin
        if (p <= v)          f_op = '0;
        else if (p >= t)     f_op = MAX;
        else if (w_str[PIX_W]) f_op = MAX;
        else                 f_op = w_str[PIX_W-1:0];
      end
      default: f_op = p;
    endcase
  endfunction

  assign w_en    = ~m_valid | m_ready;
  assign s_ready = w_en;
  assign w_acc   = s_valid & w_en;
  assign w_sof   = (r_col == '0) & (r_row == '0);
  assign w_eol   = (r_col == CW'(BEATS - 1));
  assign w_eof   = w_eol & (r_row == RW'(IMG_H - 1));
  // The sof beat already uses the operands being captured with it.
  assign w_mode  = w_sof ? mode : r_mode;
  assign w_val   = w_sof ? value : r_val;
  assign w_thr   = w_sof ? threshold : r_thr;

  // Per-lane operation and hot-pixel count on the raw input pixels.
  always_comb begin
    w_res = '0;
    w_hot = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      w_res[l*PIX_W +: PIX_W] = f_op(w_mode, s_data[l*PIX_W +: PIX_W], w_val, w_thr);
      if (s_data[l*PIX_W +: PIX_W] >= w_thr) w_hot = w_hot + LCW'(1);
    end
  end

  // Raster position of the next accepted beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_acc) begin
      if (w_eol) begin
        r_col <= '0;
        r_row <= w_eof ? '0 : r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  // Frame operands latched on the sof beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode <= '0;
      r_val  <= '0;
      r_thr  <= '0;
    end else if (w_acc && w_sof) begin
      r_mode <= mode;
      r_val  <= value;
      r_thr  <= threshold;
    end
  end

  // Two-stage pipeline: S1 holds computed pixels, S2 is the output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_sof   <= 1'b0;
      r_s1_eol   <= 1'b0;
      r_s1_eof   <= 1'b0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_sof      <= 1'b0;
      m_eol      <= 1'b0;
      m_eof      <= 1'b0;
    end else if (w_en) begin
      r_s1_valid <= s_valid;
      r_s1_data  <= w_res;
      r_s1_sof   <= w_sof;
      r_s1_eol   <= w_eol;
      r_s1_eof   <= w_eof;
      m_valid    <= r_s1_valid;
      m_data     <= r_s1_data;
      m_sof      <= r_s1_sof;
      m_eol      <= r_s1_eol;
      m_eof      <= r_s1_eof;
    end
  end

  // Hot-pixel accumulator, restarted (not discarded) on the sof beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (w_acc) begin
      r_acc <= w_sof ? HCW'(w_hot) : r_acc + HCW'(w_hot);
    end
  end

  // Publish the frame total as the eof beat moves from S1 to S2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hot_count <= '0;
      hot_valid <= 1'b0;
    end else begin
      hot_valid <= 1'b0;
      if (w_en && r_s1_valid && r_s1_eof) begin
        hot_count <= r_acc;
        hot_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_xray_pixel_stream_engine.sv
// Directed bench for xray_pixel_stream_engine: a 16x8 single-lane instance for
// the operations, flags, hot count, backpressure and reset, and a 4x2 two-lane
// instance for lane packing and shadowed mode changes.
module tb_xray_pixel_stream_engine;

  localparam int unsigned W1  = 16;
  localparam int unsigned H1  = 8;
  localparam int unsigned NB1 = W1 * H1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // single-lane instance
  logic [2:0] mode;
  logic [7:0] value, threshold, s_data, m_data;
  logic       s_valid, s_ready, m_valid, m_ready, m_sof, m_eol, m_eof, hot_valid;
  logic [7:0] hot_count;

  // two-lane instance
  logic [2:0]  mode2;
  logic [7:0]  value2, threshold2;
  logic [15:0] s_data2, m_data2;
  logic        s_valid2, s_ready2, m_valid2, m_ready2, m_sof2, m_eol2, m_eof2, hot_valid2;
  logic [3:0]  hot_count2;

  xray_pixel_stream_engine #(.PIX_W(8), .LANES(1), .IMG_W(W1), .IMG_H(H1)) u_dut (
    .clk(clk), .rst(rst), .mode(mode), .value(value), .threshold(threshold),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof),
    .hot_count(hot_count), .hot_valid(hot_valid)
  );

  xray_pixel_stream_engine #(.PIX_W(8), .LANES(2), .IMG_W(4), .IMG_H(2)) u_dut2 (
    .clk(clk), .rst(rst), .mode(mode2), .value(value2), .threshold(threshold2),
    .s_valid(s_valid2), .s_ready(s_ready2), .s_data(s_data2),
    .m_valid(m_valid2), .m_ready(m_ready2), .m_data(m_data2),
    .m_sof(m_sof2), .m_eol(m_eol2), .m_eof(m_eof2),
    .hot_count(hot_count2), .hot_valid(hot_valid2)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Output capture {sof,eol,eof,data}, hot_valid pulse count, hold-while-stalled check.
  logic [10:0] act_q[$];
  logic [10:0] exp_q[$];
  logic [18:0] q2[$];
  int          hv_cnt = 0;
  int          hv2    = 0;
  logic        bp     = 1'b0;
  logic        prev_stall = 1'b0;
  logic [10:0] held;

  always @(negedge clk) begin
    #2;
    if (prev_stall) chk("hold while stalled", {m_sof, m_eol, m_eof, m_data}, held);
    prev_stall = m_valid & ~m_ready;
    held       = {m_sof, m_eol, m_eof, m_data};
    if (m_valid && m_ready) act_q.push_back({m_sof, m_eol, m_eof, m_data});
    if (hot_valid) hv_cnt++;
    if (m_valid2 && m_ready2) q2.push_back({m_sof2, m_eol2, m_eof2, m_data2});
    if (hot_valid2) hv2++;
  end

  // Frame bookkeeping for the single-lane instance.
  int idx = 0;
  int fm, fv, ft;
  int hot_exp = 0;

  function automatic int ref_op(input int m, input int p, input int v, input int t);
    int r;
    case (m)
      1: begin r = p + v; if (r > 255) r = 255; end
      2: begin r = p - v; if (r < 0) r = 0; end
      3: r = (p >= t) ? 255 : 0;
      4: r = 255 - p;
      5: begin
        if (p <= v)      r = 0;
        else if (p >= t) r = 255;
        else begin r = 2 * (p - v); if (r > 255) r = 255; end
      end
      default: r = p;
    endcase
    return r;
  endfunction

  task automatic drive_cycle(input logic v, input logic [7:0] d, output logic acc);
    @(negedge clk);
    m_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    s_valid = v;
    s_data  = d;
    #1 acc = v & s_ready;
  endtask

  task automatic accept_beat(input logic [7:0] p, input int hand, output logic [10:0] w);
    int dv;
    if (idx == 0) begin
      fm = int'(mode); fv = int'(value); ft = int'(threshold);
      hot_exp = 0; hv_cnt = 0;
      act_q.delete(); exp_q.delete();
    end
    dv = (hand >= 0) ? hand : ref_op(fm, int'(p), fv, ft);
    if (int'(p) >= ft) hot_exp++;
    w = {idx == 0, (idx % W1) == W1 - 1, idx == NB1 - 1, 8'(dv)};
    exp_q.push_back(w);
    idx = (idx == NB1 - 1) ? 0 : idx + 1;
  endtask

  // One beat into an empty pipeline; checks the two-cycle latency and result.
  task automatic iso(input logic [7:0] p, input logic [7:0] hand, input string tag);
    logic acc;
    logic [10:0] w;
    drive_cycle(1'b1, p, acc);
    chk({tag, " accepted"}, acc, 1);
    accept_beat(p, int'(hand), w);
    drive_cycle(1'b0, 8'h00, acc);
    chk({tag, " not yet valid"}, m_valid, 0);
    drive_cycle(1'b0, 8'h00, acc);
    chk({tag, " valid"}, m_valid, 1);
    chk({tag, " data"}, m_data, hand);
    chk({tag, " sof"}, m_sof, w[10]);
  endtask

  task automatic stream(input int n, input int seed, input int chg_at, input logic [2:0] chg_mode);
    for (int i = 0; i < n; i++) begin
      logic [7:0]  p;
      logic        acc;
      logic [10:0] w;
      int          guard;
      if (i == chg_at) mode = chg_mode;
      p = 8'((i * 37 + seed * 11 + (i >> 3)) & 255);
      guard = 0;
      acc = 1'b0;
      while (!acc && guard < 100) begin
        drive_cycle(1'b1, p, acc);
        guard++;
      end
      if (!acc) chk("stream beat accepted", acc, 1);
      accept_beat(p, -1, w);
    end
    begin
      logic acc;
      drive_cycle(1'b0, 8'h00, acc);
    end
  endtask

  task automatic check_frame(input string tag, input int n_eol);
    int   guard;
    int   cs, cl, cf;
    logic acc;
    guard = 0;
    while (act_q.size() < exp_q.size() && guard < 400) begin
      drive_cycle(1'b0, 8'h00, acc);
      guard++;
    end
    repeat (2) drive_cycle(1'b0, 8'h00, acc);
    chk({tag, " beat count"}, act_q.size(), exp_q.size());
    cs = 0; cl = 0; cf = 0;
    for (int i = 0; i < act_q.size(); i++) begin
      if (i < exp_q.size()) chk($sformatf("%s beat %0d", tag, i), act_q[i], exp_q[i]);
      cs += int'(act_q[i][10]);
      cl += int'(act_q[i][9]);
      cf += int'(act_q[i][8]);
    end
    chk({tag, " sof count"}, cs, 1);
    chk({tag, " eol count"}, cl, n_eol);
    chk({tag, " eof count"}, cf, 1);
    chk({tag, " hot_valid cycles"}, hv_cnt, 1);
    chk({tag, " hot_count"}, hot_count, hot_exp);
  endtask

  logic [15:0] in1 [4] = '{16'h2010, 16'hF5A0, 16'h0080, 16'h7F81};
  logic [18:0] ex1 [4] = '{{3'b100, 16'h3020}, {3'b010, 16'hFFB0}, {3'b000, 16'h1090}, {3'b011, 16'h8F91}};
  logic [15:0] in2 [4] = '{16'h00FF, 16'h1234, 16'h1234, 16'h1234};
  logic [18:0] ex2 [4] = '{{3'b100, 16'hFF00}, {3'b010, 16'hEDCB}, {3'b000, 16'hEDCB}, {3'b011, 16'hEDCB}};

  initial begin
    logic acc;
    rst = 1'b1;
    mode = 3'd0; value = 8'd0; threshold = 8'd0; s_valid = 1'b0; s_data = 8'd0; m_ready = 1'b1;
    mode2 = 3'd0; value2 = 8'd0; threshold2 = 8'd0; s_valid2 = 1'b0; s_data2 = 16'd0; m_ready2 = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset m_valid", m_valid, 0);
    chk("reset s_ready", s_ready, 1);
    chk("reset hot_count", hot_count, 0);
    chk("reset hot_valid", hot_valid, 0);

    // Mode 1 frame; mode input switched to 4 at frame beat 50 must not take effect.
    mode = 3'd1; value = 8'd60; threshold = 8'hA0;
    iso(8'h10, 8'h4C, "mode1 0x10");
    iso(8'hF0, 8'hFF, "mode1 0xF0");
    iso(8'hFF, 8'hFF, "mode1 0xFF");
    stream(125, 1, 47, 3'd4);
    check_frame("frame mode1", 8);

    // Next frame picks up mode 4.
    iso(8'h10, 8'hEF, "mode4 next frame");
    stream(127, 2, -1, 3'd4);
    check_frame("frame mode4", 8);

    mode = 3'd2; value = 8'd60;
    iso(8'h20, 8'h00, "mode2 0x20");
    iso(8'h50, 8'h14, "mode2 0x50");
    stream(126, 3, -1, 3'd2);
    check_frame("frame mode2", 8);

    mode = 3'd3; threshold = 8'hA0;
    iso(8'h9F, 8'h00, "mode3 0x9F");
    iso(8'hA0, 8'hFF, "mode3 0xA0");
    iso(8'hFF, 8'hFF, "mode3 0xFF");
    stream(125, 4, -1, 3'd3);
    check_frame("frame mode3", 8);

    mode = 3'd5; value = 8'h40; threshold = 8'hC0;
    iso(8'h30, 8'h00, "mode5 0x30");
    iso(8'h50, 8'h20, "mode5 0x50");
    iso(8'h90, 8'hA0, "mode5 0x90");
    iso(8'hC0, 8'hFF, "mode5 0xC0");
    stream(124, 5, -1, 3'd5);
    check_frame("frame mode5", 8);

    // Random downstream backpressure over a whole frame.
    bp = 1'b1;
    mode = 3'd3; value = 8'd0; threshold = 8'hA0;
    stream(128, 6, -1, 3'd3);
    check_frame("frame backpressure", 8);
    bp = 1'b0;

    // Reset in the middle of a frame.
    mode = 3'd0;
    stream(100, 7, -1, 3'd0);
    @(negedge clk);
    rst = 1'b1;
    hv_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    idx = 0;
    act_q.delete();
    exp_q.delete();
    repeat (3) drive_cycle(1'b0, 8'h00, acc);
    chk("mid-frame reset hot_valid", hv_cnt, 0);
    chk("mid-frame reset hot_count", hot_count, 0);
    chk("mid-frame reset m_valid", m_valid, 0);
    iso(8'h33, 8'h33, "after reset");

    // Two-lane instance: mode 1 frame with a mode change at beat 2, then a mode 4 frame.
    mode2 = 3'd1; value2 = 8'h10; threshold2 = 8'h80;
    q2.delete(); hv2 = 0;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      if (b == 2) mode2 = 3'd4;
      s_valid2 = 1'b1;
      s_data2  = in1[b];
      #1 chk("lanes2 s_ready", s_ready2, 1);
    end
    @(negedge clk);
    s_valid2 = 1'b0;
    repeat (4) @(negedge clk);
    #3;
    chk("lanes2 f1 beats", q2.size(), 4);
    for (int b = 0; b < 4; b++) if (b < q2.size()) chk($sformatf("lanes2 f1 beat %0d", b), q2[b], ex1[b]);
    chk("lanes2 f1 hot_valid cycles", hv2, 1);
    chk("lanes2 f1 hot_count", hot_count2, 4);

    q2.delete(); hv2 = 0;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      s_valid2 = 1'b1;
      s_data2  = in2[b];
    end
    @(negedge clk);
    s_valid2 = 1'b0;
    repeat (4) @(negedge clk);
    #3;
    chk("lanes2 f2 beats", q2.size(), 4);
    for (int b = 0; b < 4; b++) if (b < q2.size()) chk($sformatf("lanes2 f2 beat %0d", b), q2[b], ex2[b]);
    chk("lanes2 f2 hot_valid cycles", hv2, 1);
    chk("lanes2 f2 hot_count", hot_count2, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
